stm_trace_arbiter: RTL and testbench

STM_TRACE_ARBITER -- requirements
Module: stm_trace_arbiter

---
 rtl/stm_trace_arbiter.sv | 173 +++++++++++++++++
 tb/tb_stm_trace_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/stm_trace_arbiter.sv
// STM trace arbiter: per-core writeback event FIFOs drained round-robin into a
// single registered output with valid/ready handshake and overflow tracking.
module stm_trace_arbiter #(
    parameter int NUMCORES   = 4,
    parameter int FIFO_DEPTH = 4,
    localparam int CW        = (NUMCORES > 1) ? $clog2(NUMCORES) : 1
) (
    input  logic                     clk,
    input  logic                     rst_sys_n,
    input  logic [NUMCORES-1:0]      in_valid,
    input  logic [5*NUMCORES-1:0]    in_reg,
    input  logic [32*NUMCORES-1:0]   in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CW-1:0]            out_core,
    output logic [4:0]               out_reg,
    output logic [31:0]              out_data,
    output logic                     out_lost,
    output logic [NUMCORES-1:0]      ovf_sticky,
    input  logic                     ovf_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 38;  // {lost, reg[4:0], data[31:0]}

    logic [EW-1:0]         mem_q    [NUMCORES][FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q [NUMCORES];
    logic [AW-1:0]         rd_ptr_q [NUMCORES];
    logic [AW:0]           count_q  [NUMCORES];
    logic [NUMCORES-1:0]   lost_q;
    logic [CW-1:0]         last_grant_q;

    logic                  out_valid_q;
    logic [CW-1:0]         out_core_q;
    logic [4:0]            out_reg_q;
    logic [31:0]           out_data_q;
    logic                  out_lost_q;
    logic [NUMCORES-1:0]   ovf_q;

    logic [NUMCORES-1:0]   nonempty;
    logic [NUMCORES-1:0]   full;
    logic [NUMCORES-1:0]   push;
    logic [NUMCORES-1:0]   pop;
    logic [NUMCORES-1:0]   drop;
    logic                  out_free;
    logic                  found;
    logic [CW-1:0]         grant;
    logic [CW:0]           cand_sum;
    logic [EW-1:0]         head;

    assign out_free = !out_valid_q || out_ready;

    // FIFO occupancy flags
    always_comb begin
        nonempty = '0;
        full     = '0;
        for (int unsigned i = 0; i < NUMCORES; i++) begin
            nonempty[i] = (count_q[i] != '0);
            full[i]     = (count_q[i] == (AW+1)'(FIFO_DEPTH));
        end
    end

    // Round-robin search from last_grant+1, wrapping modulo NUMCORES
    always_comb begin
        found    = 1'b0;
        grant    = last_grant_q;
        cand_sum = '0;
        for (int unsigned k = 0; k < NUMCORES; k++) begin
            cand_sum = {1'b0, last_grant_q} + (CW+1)'(k) + (CW+1)'(1);
            if (cand_sum >= (CW+1)'(NUMCORES)) begin
                cand_sum = cand_sum - (CW+1)'(NUMCORES);
            end
            if (!found && nonempty[cand_sum[CW-1:0]]) begin
                found = 1'b1;
                grant = cand_sum[CW-1:0];
            end
        end
    end

    // Per-core push/pop/drop decisions; a full FIFO may accept when popped this cycle
    always_comb begin
        pop  = '0;
        push = '0;
        drop = '0;
        for (int unsigned i = 0; i < NUMCORES; i++) begin
            pop[i]  = out_free && found && (grant == CW'(i));
            push[i] = in_valid[i] && (!full[i] || pop[i]);
            drop[i] = in_valid[i] && full[i] && !pop[i];
        end
    end

    assign head = mem_q[grant][rd_ptr_q[grant]];

    // FIFO storage; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUMCORES; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= {lost_q[i], in_reg[5*i +: 5], in_data[32*i +: 32]};
            end
        end
    end

    // FIFO pointers, counts and per-core lost flags
    always_ff @(posedge clk or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            for (int unsigned i = 0; i < NUMCORES; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            lost_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUMCORES; i++) begin
                if (push[i]) begin
                    wr_ptr_q[i] <= wr_ptr_q[i] + AW'(1);
                end
                if (pop[i]) begin
                    rd_ptr_q[i] <= rd_ptr_q[i] + AW'(1);
                end
                if (push[i] && !pop[i]) begin
                    count_q[i] <= count_q[i] + (AW+1)'(1);
                end else if (pop[i] && !push[i]) begin
                    count_q[i] <= count_q[i] - (AW+1)'(1);
                end
                if (push[i]) begin
                    lost_q[i] <= 1'b0;
                end else if (drop[i]) begin
                    lost_q[i] <= 1'b1;
                end
            end
        end
    end

    // Output register and round-robin pointer; load on the same edge as the pop
    always_ff @(posedge clk or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            out_valid_q  <= 1'b0;
            out_core_q   <= '0;
            out_reg_q    <= '0;
            out_data_q   <= '0;
            out_lost_q   <= 1'b0;
            last_grant_q <= CW'(NUMCORES - 1);
        end else if (out_free) begin
            if (found) begin
                out_valid_q  <= 1'b1;
                out_core_q   <= grant;
                out_lost_q   <= head[37];
                out_reg_q    <= head[36:32];
                out_data_q   <= head[31:0];
                last_grant_q <= grant;
            end else begin
                out_valid_q  <= 1'b0;
            end
        end
    end

    // Sticky overflow bits; a drop in the clear cycle keeps its bit set
    always_ff @(posedge clk or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= (ovf_clr ? '0 : ovf_q) | drop;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_core   = out_core_q;
    assign out_reg    = out_reg_q;
    assign out_data   = out_data_q;
    assign out_lost   = out_lost_q;
    assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_stm_trace_arbiter.sv
// Directed self-checking bench for stm_trace_arbiter (NUMCORES=4, FIFO_DEPTH=4).
module tb_stm_trace_arbiter;

    logic         clk = 1'b0;
    logic         rst_sys_n;
    logic [3:0]   in_valid;
    logic [19:0]  in_reg;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_core;
    logic [4:0]   out_reg;
    logic [31:0]  out_data;
    logic         out_lost;
    logic [3:0]   ovf_sticky;
    logic         ovf_clr;

    int n_checks = 0;
    int n_pass   = 0;

    stm_trace_arbiter #(.NUMCORES(4), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst_sys_n  (rst_sys_n),
        .in_valid   (in_valid),
        .in_reg     (in_reg),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_core   (out_core),
        .out_reg    (out_reg),
        .out_data   (out_data),
        .out_lost   (out_lost),
        .ovf_sticky (ovf_sticky),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input int c, input logic [4:0] r, input logic [31:0] d);
        in_valid[c]        = 1'b1;
        in_reg[5*c +: 5]   = r;
        in_data[32*c +: 32] = d;
    endtask

    task automatic expect_out(input string tag, input logic [1:0] c, input logic [4:0] r,
                              input logic [31:0] d, input logic l);
        check_eq({tag, ".valid"}, 64'(out_valid), 64'(1'b1));
        check_eq({tag, ".core"},  64'(out_core),  64'(c));
        check_eq({tag, ".reg"},   64'(out_reg),   64'(r));
        check_eq({tag, ".data"},  64'(out_data),  64'(d));
        check_eq({tag, ".lost"},  64'(out_lost),  64'(l));
    endtask

    initial begin
        rst_sys_n = 1'b0;
        in_valid  = '0;
        in_reg    = '0;
        in_data   = '0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        step();
        step();
        check_eq("rst.valid", 64'(out_valid), 64'd0);
        check_eq("rst.core",  64'(out_core),  64'd0);
        check_eq("rst.reg",   64'(out_reg),   64'd0);
        check_eq("rst.data",  64'(out_data),  64'd0);
        check_eq("rst.lost",  64'(out_lost),  64'd0);
        check_eq("rst.ovf",   64'(ovf_sticky), 64'd0);
        rst_sys_n = 1'b1;
        step();

        // Fairness: two simultaneous bursts from all cores
        out_ready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            for (int c = 0; c < 4; c++) drive(c, 5'(c + 4*b), 32'h100 * (b + 1) + 32'(c));
            step();
            in_valid = '0;
            check_eq("rr.lat", 64'(out_valid), 64'd0);
            for (int c = 0; c < 4; c++) begin
                step();
                expect_out("rr", 2'(c), 5'(c + 4*b), 32'h100 * (b + 1) + 32'(c), 1'b0);
            end
            step();
            check_eq("rr.idle", 64'(out_valid), 64'd0);
        end

        // Single event latency
        drive(2, 5'd3, 32'hDEADBEEF);
        step();
        in_valid = '0;
        check_eq("single.t1", 64'(out_valid), 64'd0);
        step();
        expect_out("single", 2'd2, 5'd3, 32'hDEADBEEF, 1'b0);
        step();
        check_eq("single.idle", 64'(out_valid), 64'd0);

        // Overflow on core 1; ovf_clr coincides with the drop (set wins)
        out_ready = 1'b0;
        for (int d = 1; d <= 6; d++) begin
            drive(1, 5'(d), 32'(d));
            ovf_clr = (d == 6);
            step();
        end
        in_valid = '0;
        ovf_clr  = 1'b0;
        expect_out("ovf.hold1", 2'd1, 5'd1, 32'd1, 1'b0);
        check_eq("ovf.sticky", 64'(ovf_sticky), 64'h2);
        out_ready = 1'b1;
        step();
        expect_out("ovf.d2", 2'd1, 5'd2, 32'd2, 1'b0);
        out_ready = 1'b0;
        drive(1, 5'd7, 32'd7);
        step();
        in_valid = '0;
        expect_out("ovf.d2hold", 2'd1, 5'd2, 32'd2, 1'b0);
        out_ready = 1'b1;
        for (int d = 3; d <= 5; d++) begin
            step();
            expect_out("ovf.dn", 2'd1, 5'(d), 32'(d), 1'b0);
        end
        step();
        expect_out("ovf.d7", 2'd1, 5'd7, 32'd7, 1'b1);
        step();
        check_eq("ovf.idle", 64'(out_valid), 64'd0);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check_eq("ovf.clr", 64'(ovf_sticky), 64'd0);

        // Backpressure: core 3 wins (last grant was 1), held 5 cycles, then core 0 with no bubble
        out_ready = 1'b0;
        drive(0, 5'd9, 32'hAAAA0000);
        drive(3, 5'h1E, 32'hBBBB3333);
        step();
        in_valid = '0;
        step();
        expect_out("bp.first", 2'd3, 5'h1E, 32'hBBBB3333, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step();
            expect_out("bp.hold", 2'd3, 5'h1E, 32'hBBBB3333, 1'b0);
        end
        out_ready = 1'b1;
        step();
        expect_out("bp.next", 2'd0, 5'd9, 32'hAAAA0000, 1'b0);
        step();
        check_eq("bp.idle", 64'(out_valid), 64'd0);

        // Full FIFO push accepted because of a simultaneous pop
        out_ready = 1'b0;
        for (int d = 0; d < 5; d++) begin
            drive(0, 5'(d), 32'h10 + 32'(d));
            step();
        end
        in_valid = '0;
        expect_out("fp.hold", 2'd0, 5'd0, 32'h10, 1'b0);
        check_eq("fp.ovf_pre", 64'(ovf_sticky), 64'd0);
        out_ready = 1'b1;
        drive(0, 5'd5, 32'h15);
        step();
        in_valid = '0;
        expect_out("fp.d1", 2'd0, 5'd1, 32'h11, 1'b0);
        check_eq("fp.ovf", 64'(ovf_sticky), 64'd0);
        for (int d = 2; d <= 5; d++) begin
            step();
            expect_out("fp.dn", 2'd0, 5'(d), 32'h10 + 32'(d), 1'b0);
        end
        step();
        check_eq("fp.idle", 64'(out_valid), 64'd0);
        check_eq("fp.ovf_end", 64'(ovf_sticky), 64'd0);

        // Reset mid-burst with buffered events and a pending lost flag
        out_ready = 1'b0;
        for (int d = 0; d < 6; d++) begin
            drive(0, 5'(d), 32'h20 + 32'(d));
            step();
        end
        in_valid = '0;
        check_eq("mr.pre_ovf",   64'(ovf_sticky), 64'h1);
        check_eq("mr.pre_valid", 64'(out_valid),  64'd1);
        #2;
        rst_sys_n = 1'b0;
        in_valid  = 4'hF;
        #1;
        check_eq("mr.async_valid", 64'(out_valid),  64'd0);
        check_eq("mr.async_ovf",   64'(ovf_sticky), 64'd0);
        check_eq("mr.async_data",  64'(out_data),   64'd0);
        step();
        step();
        in_valid  = '0;
        rst_sys_n = 1'b1;
        out_ready = 1'b1;
        step();
        check_eq("mr.quiet1", 64'(out_valid), 64'd0);
        step();
        check_eq("mr.quiet2", 64'(out_valid), 64'd0);
        check_eq("mr.ovf",    64'(ovf_sticky), 64'd0);
        drive(0, 5'd4, 32'hCAFE0001);
        step();
        in_valid = '0;
        step();
        expect_out("mr.first", 2'd0, 5'd4, 32'hCAFE0001, 1'b0);
        step();
        check_eq("mr.idle", 64'(out_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
